pc_sequencer: RTL and testbench

// - Program-counter register and next-PC selector for the mono-cycle MIPS datapath.
// - Consumes the branch target from the PCBranch adder, the jump fields and the jr

---
 rtl/mips_pkg.sv | 21 ++
 rtl/pc_next_mux.sv | 47 ++++
 rtl/pc_sequencer.sv | 101 ++++++++++
 tb/tb_pc_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the mono-cycle MIPS datapath: PC sequencer states,
// next-PC select encoding and the default reset vector.
package mips_pkg;

    localparam int          PC_ADDR_W       = 32;
    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_1000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } pc_state_t;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC priority select (jr > j > branch > sequential) with a
// flag raised when the chosen target is not word aligned.
module pc_next_mux
    import mips_pkg::*;
#(
    parameter int ADDR_W = PC_ADDR_W
) (
    input  logic [ADDR_W-1:0] pc_plus4_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              jump_i,
    input  logic [25:0]       jump_index_i,
    input  logic              jump_reg_i,
    input  logic [ADDR_W-1:0] jr_target_i,
    output logic [ADDR_W-1:0] next_pc_o,
    output logic              misaligned_o
);

    pc_sel_t sel;

    always_comb begin
        sel = SEL_SEQ;
        if (jump_reg_i) begin
            sel = SEL_JR;
        end else if (jump_i) begin
            sel = SEL_J;
        end else if (branch_taken_i) begin
            sel = SEL_BR;
        end
    end

    // Jump region comes from the already-incremented PC, so a wrap at the top
    // of memory selects region 0.
    always_comb begin
        next_pc_o = pc_plus4_i;
        case (sel)
            SEL_SEQ: next_pc_o = pc_plus4_i;
            SEL_BR:  next_pc_o = branch_target_i;
            SEL_J:   next_pc_o = {pc_plus4_i[ADDR_W-1:ADDR_W-4], jump_index_i, 2'b00};
            SEL_JR:  next_pc_o = jr_target_i;
            default: next_pc_o = pc_plus4_i;
        endcase
    end

    assign misaligned_o = (next_pc_o[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register and control FSM for the mono-cycle MIPS datapath;
// holds the fetch PC, applies stalls and freezes on misaligned redirects.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR,
    parameter int          ADDR_W       = PC_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    input  logic              jump_reg,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              fetch_valid,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_pc
);

    pc_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;

    logic [ADDR_W-1:0] next_pc;
    logic              misaligned;

    assign pc_plus4 = pc_q + ADDR_W'(4);

    pc_next_mux #(
        .ADDR_W (ADDR_W)
    ) u_next_mux (
        .pc_plus4_i      (pc_plus4),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .jump_i          (jump),
        .jump_index_i    (jump_index),
        .jump_reg_i      (jump_reg),
        .jr_target_i     (jr_target),
        .next_pc_o       (next_pc),
        .misaligned_o    (misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR[ADDR_W-1:0];
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    // A misaligned target is never loaded; the PC of the offending
    // instruction is captured instead and the sequencer parks in FAULT.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        case (state_q)
            BOOT: begin
                if (!stall) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (misaligned) begin
                        state_d    = FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = pc_q;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    assign pc          = pc_q;
    assign fetch_valid = (state_q == RUN);
    assign fault       = fault_q;
    assign fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push expected state,
// a monitor pops and compares one entry after every clock edge.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        fault;
    logic [31:0] fault_pc;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        fv;
        logic        fault;
        logic [31:0] fpc;
    } exp_t;

    exp_t expQ[$];
    int   totalChecks = 0;
    int   badChecks   = 0;
    bit   stimDone    = 1'b0;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .jump_reg      (jump_reg),
        .jr_target     (jr_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .fetch_valid   (fetch_valid),
        .fault         (fault),
        .fault_pc      (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkField(input string name, input string field,
                              input logic [31:0] act, input logic [31:0] exp);
        totalChecks++;
        if (act !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, act, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField(e.name, "pc",          pc,                    e.pc);
        checkField(e.name, "pc_plus4",    pc_plus4,              e.pc + 32'd4);
        checkField(e.name, "fetch_valid", {31'd0, fetch_valid},  {31'd0, e.fv});
        checkField(e.name, "fault",       {31'd0, fault},        {31'd0, e.fault});
        checkField(e.name, "fault_pc",    fault_pc,              e.fpc);
    endtask

    // Drive one cycle of inputs and record the state expected after the edge.
    task automatic applyStimulus(input string name, input logic rst, input logic stl,
                                 input logic br, input logic [31:0] bt,
                                 input logic j, input logic [25:0] ji,
                                 input logic jr, input logic [31:0] jrt,
                                 input logic [31:0] epc, input logic efv,
                                 input logic eflt, input logic [31:0] efpc);
        exp_t e;
        @(negedge clk);
        reset         = rst;
        stall         = stl;
        branch_taken  = br;
        branch_target = bt;
        jump          = j;
        jump_index    = ji;
        jump_reg      = jr;
        jr_target     = jrt;
        e.name  = name;
        e.pc    = epc;
        e.fv    = efv;
        e.fault = eflt;
        e.fpc   = efpc;
        expQ.push_back(e);
        @(posedge clk);
    endtask

    task automatic resetAndBoot();
        applyStimulus("rst",  1, 0, 0, 0, 0, 0, 0, 0, 32'h1000, 0, 0, 0);
        applyStimulus("boot", 0, 0, 0, 0, 0, 0, 0, 0, 32'h1000, 1, 0, 0);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_index = '0; jump_reg = 1'b0; jr_target = '0;

        resetAndBoot();
        applyStimulus("seq1",   0, 0, 0, 0, 0, 0, 0, 0, 32'h1004, 1, 0, 0);
        applyStimulus("seq2",   0, 0, 0, 0, 0, 0, 0, 0, 32'h1008, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus("stall", 0, 1, 1, 32'h1040, 0, 0, 0, 0, 32'h1008, 1, 0, 0);
        applyStimulus("brRel",  0, 0, 1, 32'h1040, 0, 0, 0, 0, 32'h1040, 1, 0, 0);

        applyStimulus("rst",       1, 0, 0, 0, 0, 0, 0, 0, 32'h1000, 0, 0, 0);
        applyStimulus("bootStall", 0, 1, 0, 0, 0, 0, 0, 0, 32'h1000, 0, 0, 0);
        applyStimulus("boot",      0, 0, 0, 0, 0, 0, 0, 0, 32'h1000, 1, 0, 0);
        applyStimulus("branch",    0, 0, 1, 32'h1014, 0, 0, 0, 0, 32'h1014, 1, 0, 0);

        resetAndBoot();
        applyStimulus("negBr",  0, 0, 1, 32'h0FF4, 0, 0, 0, 0, 32'h0FF4, 1, 0, 0);

        resetAndBoot();
        applyStimulus("seq",     0, 0, 0, 0, 0, 0, 0, 0, 32'h1004, 1, 0, 0);
        applyStimulus("jumpPri", 0, 0, 1, 32'h1001, 1, 26'h0000400, 0, 0, 32'h1000, 1, 0, 0);
        applyStimulus("jrPri",   0, 0, 1, 32'h1014, 1, 26'h0000400, 1, 32'h2000, 32'h2000, 1, 0, 0);
        applyStimulus("ignBad",  0, 0, 0, 32'h1003, 0, 0, 0, 32'h2002, 32'h2004, 1, 0, 0);
        applyStimulus("toTop",   0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0);
        applyStimulus("wrapSeq", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 1, 0, 0);
        applyStimulus("toTop2",  0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0);
        applyStimulus("wrapJmp", 0, 0, 0, 0, 1, 26'h0000010, 0, 0, 32'h0000_0040, 1, 0, 0);

        resetAndBoot();
        applyStimulus("brBad",     0, 0, 1, 32'h1022, 0, 0, 0, 0, 32'h1000, 0, 1, 32'h1000);
        applyStimulus("faultHold", 0, 0, 1, 32'h1014, 0, 0, 0, 0, 32'h1000, 0, 1, 32'h1000);

        resetAndBoot();
        applyStimulus("br1010",     0, 0, 1, 32'h1010, 0, 0, 0, 0, 32'h1010, 1, 0, 0);
        applyStimulus("jrBad",      0, 0, 0, 0, 0, 0, 1, 32'h2002, 32'h1010, 0, 1, 32'h1010);
        applyStimulus("faultStall", 0, 1, 0, 0, 0, 0, 0, 0, 32'h1010, 0, 1, 32'h1010);
        applyStimulus("faultSeq",   0, 0, 0, 0, 0, 0, 0, 0, 32'h1010, 0, 1, 32'h1010);
        applyStimulus("clrRst",     1, 0, 0, 0, 0, 0, 0, 0, 32'h1000, 0, 0, 0);
        applyStimulus("clrBoot",    0, 0, 0, 0, 0, 0, 0, 0, 32'h1000, 1, 0, 0);

        stimDone = 1'b1;
    end

    initial begin
        wait (stimDone);
        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clk);
        totalChecks++;
        if (expQ.size() != 0) begin
            badChecks++;
            $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
